puf_eval_sequencer: RTL and testbench

//  Sequences repeated evaluations of the K-lane XOR arbiter PUF (xor_apuf) for one host request.

---
 rtl/puf_eval_sequencer.sv | 170 +++++++++++++++++
 tb/tb_puf_eval_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_eval_sequencer.sv
// Drives repeated evaluations of an XOR arbiter PUF and majority-votes NREP responses.
// Optional WAIT-state watchdog enabled by defining PUF_TIMEOUT_EN.
module puf_eval_sequencer #(
  parameter int N      = 64,
  parameter int K      = 8,
  parameter int NREP   = 7,
  parameter int SETTLE = 4,
  parameter int GAP    = 4,
  parameter int TOUT   = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(N/8)-1:0]   wr_addr,
  input  logic [7:0]               wr_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     resp_bit,
  output logic [K-1:0]             resp_a,
  output logic                     err,
  output logic [N-1:0]             puf_chal,
  output logic                     puf_trig,
  input  logic                     puf_resp_ready,
  input  logic                     puf_resp_bit,
  input  logic [K-1:0]             puf_resp_a
);

  localparam int CW   = $clog2(NREP + 1);
  localparam int TMAX = (TOUT > SETTLE) ? ((TOUT > GAP) ? TOUT : GAP)
                                        : ((SETTLE > GAP) ? SETTLE : GAP);
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] C_NREP   = CW'(NREP);
  localparam logic [CW-1:0] C_HALF   = CW'(NREP / 2);
  localparam logic [TW-1:0] T_SETTLE = TW'(SETTLE - 1);
  localparam logic [TW-1:0] T_GAP    = TW'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_FIRE, S_WAIT, S_CAP, S_GAP, S_DONE
  } state_t;

  state_t          r_state;
  logic [N-1:0]    r_chal;
  logic [TW-1:0]   r_tmr;
  logic [CW-1:0]   r_rep;
  logic [CW-1:0]   r_ones_x;
  logic [CW-1:0]   r_ones_a [K];
  logic            r_busy;
  logic            r_done;
  logic            r_bit;
  logic [K-1:0]    r_a;
  logic            r_trig;

  assign busy     = r_busy;
  assign done     = r_done;
  assign resp_bit = r_bit;
  assign resp_a   = r_a;
  assign puf_chal = r_chal;
  assign puf_trig = r_trig;

`ifdef PUF_TIMEOUT_EN
  localparam logic [TW-1:0] T_TOUT = TW'(TOUT - 1);
  logic r_to;
  logic r_err;
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_chal   <= '0;
      r_tmr    <= '0;
      r_rep    <= '0;
      r_ones_x <= '0;
      for (int unsigned i = 0; i < K; i++) r_ones_a[i] <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_bit    <= 1'b0;
      r_a      <= '0;
      r_trig   <= 1'b0;
`ifdef PUF_TIMEOUT_EN
      r_to     <= 1'b0;
      r_err    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      // A write coinciding with an accepted start still lands before ARM.
      if (wr_en && r_state == S_IDLE) r_chal[{wr_addr, 3'b000} +: 8] <= wr_data;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rep    <= '0;
            r_ones_x <= '0;
            for (int unsigned i = 0; i < K; i++) r_ones_a[i] <= '0;
            r_tmr    <= '0;
            r_busy   <= 1'b1;
`ifdef PUF_TIMEOUT_EN
            r_to     <= 1'b0;
            r_err    <= 1'b0;
`endif
            r_state  <= S_ARM;
          end
        end
        S_ARM: begin
          if (r_tmr == T_SETTLE) begin
            r_tmr   <= '0;
            r_state <= S_FIRE;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        S_FIRE: begin
          r_trig  <= 1'b1;
          r_tmr   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (puf_resp_ready) begin
            r_state <= S_CAP;
`ifdef PUF_TIMEOUT_EN
          end else if (r_tmr == T_TOUT) begin
            r_to    <= 1'b1;
            r_trig  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_tmr <= r_tmr + TW'(1);
`endif
          end
        end
        S_CAP: begin
          r_ones_x <= r_ones_x + CW'(puf_resp_bit);
          for (int unsigned i = 0; i < K; i++)
            r_ones_a[i] <= r_ones_a[i] + CW'(puf_resp_a[i]);
          r_rep   <= r_rep + CW'(1);
          r_trig  <= 1'b0;
          r_tmr   <= '0;
          r_state <= S_GAP;
        end
        S_GAP: begin
          if (r_tmr == T_GAP) begin
            r_tmr   <= '0;
            r_state <= (r_rep == C_NREP) ? S_DONE : S_ARM;
          end else begin
            r_tmr <= r_tmr + TW'(1);
          end
        end
        S_DONE: begin
          r_bit <= (r_ones_x > C_HALF);
          for (int unsigned i = 0; i < K; i++) r_a[i] <= (r_ones_a[i] > C_HALF);
`ifdef PUF_TIMEOUT_EN
          if (r_to) begin
            r_err <= 1'b1;
            r_bit <= 1'b0;
            r_a   <= '0;
          end
`endif
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Scoreboard bench for puf_eval_sequencer with a simple arbiter-PUF response model.
module tb_puf_eval_sequencer;

  localparam int N = 64;
  localparam int K = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          start = 1'b0;
  logic          busy, done, resp_bit, err, puf_trig;
  logic [K-1:0]  resp_a;
  logic [N-1:0]  puf_chal;
  logic          puf_resp_ready = 1'b0;
  logic          puf_resp_bit = 1'b0;
  logic [K-1:0]  puf_resp_a = '0;

  puf_eval_sequencer #(.N(64), .K(8), .NREP(3), .SETTLE(2), .GAP(2), .TOUT(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .resp_bit(resp_bit), .resp_a(resp_a),
    .err(err), .puf_chal(puf_chal), .puf_trig(puf_trig),
    .puf_resp_ready(puf_resp_ready), .puf_resp_bit(puf_resp_bit), .puf_resp_a(puf_resp_a)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rbit;
    logic [7:0]  ra;
    logic        rerr;
    int          pulses;
    logic [63:0] chal;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_done   = 0;

  // PUF model state
  logic        model_en = 1'b0;
  logic        ev_bit [3];
  logic [7:0]  ev_a   [3];
  int          ev_idx = 0;
  int          pulses = 0;
  int          wcnt   = 0;
  logic        trig_q = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response model: ready rises 3 cycles after trigger rise, drops when trigger falls.
  always @(negedge clk) begin
    if (rst || !puf_trig) begin
      if (puf_resp_ready) ev_idx++;
      puf_resp_ready = 1'b0;
      wcnt = 0;
    end else begin
      if (!trig_q) pulses++;
      wcnt++;
      if (model_en && wcnt == 3) begin
        puf_resp_ready = 1'b1;
        puf_resp_bit   = ev_bit[ev_idx % 3];
        puf_resp_a     = ev_a[ev_idx % 3];
      end
    end
    trig_q = puf_trig;
  end

  // Monitor: compare every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      n_done++;
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no done");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_bit", 64'(resp_bit), 64'(e.rbit));
        chk("resp_a",   64'(resp_a),   64'(e.ra));
        chk("err",      64'(err),      64'(e.rerr));
        chk("trig_pulses", 64'(pulses), 64'(e.pulses));
        chk("chal_at_done", puf_chal, e.chal);
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic set_evals(input logic b0, b1, b2, input logic [7:0] a0, a1, a2);
    ev_bit[0] = b0; ev_bit[1] = b1; ev_bit[2] = b2;
    ev_a[0] = a0;   ev_a[1] = a1;   ev_a[2] = a2;
    ev_idx = 0;
  endtask

  task automatic write_byte(input logic [2:0] addr, input logic [7:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic push_exp(input logic b, input logic [7:0] a, input logic e,
                          input int p, input logic [63:0] c);
    exp_t x;
    x.rbit = b; x.ra = a; x.rerr = e; x.pulses = p; x.chal = c;
    q.push_back(x);
  endtask

  task automatic pulse_start();
    pulses = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int target;
    bit seen;
    target = n_done + 1;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (n_done >= target) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got no done within 300 cycles expected done", name);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [63:0] c;
    int          i;
    set_evals(1'b1, 1'b1, 1'b1, 8'hA5, 8'hA5, 8'hA5);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_trig", 64'(puf_trig), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_chal", puf_chal, 64'd0);
    chk("rst_resp_a", 64'(resp_a), 64'd0);
    chk("rst_err", 64'(err), 64'd0);

    // 1: reset mid-WAIT aborts without a done pulse
    write_byte(3'd2, 8'h5C);
    model_en = 1'b0;
    pulse_start();
    chk("busy_after_start", 64'(busy), 64'd1);
    i = 0;
    while (!puf_trig && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk("trig_before_reset", 64'(puf_trig), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("midrst_trig", 64'(puf_trig), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_chal", puf_chal, 64'd0);
    repeat (30) @(negedge clk);

    // 2: byte-wise load and three identical evaluations
    model_en = 1'b1;
    for (int b = 0; b < 8; b++) write_byte(3'(b), 8'(b + 1));
    c = 64'h0807060504030201;
    chk("load_chal", puf_chal, c);
    set_evals(1'b1, 1'b1, 1'b1, 8'hA5, 8'hA5, 8'hA5);
    push_exp(1'b1, 8'hA5, 1'b0, 3, c);
    pulse_start();
    wait_done("load_done");

    // 3: majority vote across differing evaluations
    set_evals(1'b1, 1'b0, 1'b0, 8'hFF, 8'h0F, 8'hF0);
    push_exp(1'b0, 8'hFF, 1'b0, 3, c);
    pulse_start();
    wait_done("vote_done");

    // 4: writes and start are locked out while busy
    set_evals(1'b1, 1'b1, 1'b1, 8'hA5, 8'hA5, 8'hA5);
    push_exp(1'b1, 8'hA5, 1'b0, 3, c);
    pulse_start();
    repeat (2) @(negedge clk);
    start = 1'b1;
    write_byte(3'd0, 8'hFF);
    start = 1'b0;
    chk("lockout_byte0", 64'(puf_chal[7:0]), 64'h01);
    wait_done("lockout_done");
    repeat (20) @(negedge clk);

    // 5: write in the same cycle start is accepted
    c = 64'hAA07060504030201;
    push_exp(1'b1, 8'hA5, 1'b0, 3, c);
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'hAA;
    pulse_start();
    wr_en = 1'b0;
    chk("samecycle_byte7", 64'(puf_chal[63:56]), 64'hAA);
    wait_done("samecycle_done");

    // 6: PUF never answers
    model_en = 1'b0;
`ifdef PUF_TIMEOUT_EN
    push_exp(1'b0, 8'h00, 1'b1, 1, c);
    pulse_start();
    wait_done("timeout_done");
    model_en = 1'b1;
    set_evals(1'b0, 1'b1, 1'b1, 8'h3C, 8'h3C, 8'h3C);
    push_exp(1'b1, 8'h3C, 1'b0, 3, c);
    pulse_start();
    chk("err_cleared_on_start", 64'(err), 64'd0);
    wait_done("after_timeout_done");
`else
    pulse_start();
    repeat (60) @(negedge clk);
    chk("stuck_busy", 64'(busy), 64'd1);
    chk("stuck_err", 64'(err), 64'd0);
    chk("stuck_trig", 64'(puf_trig), 64'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("stuck_rst_busy", 64'(busy), 64'd0);
`endif

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
